// File: rtl/sram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sram_bist_pkg
// Shared types for the 2-port SRAM March C- BIST controller:
//   - bist_state_e : controller FSM states (IDLE -> RUN -> DRAIN -> DONE)
//   - march_elem_t : one March element (direction, op sequence, data polarity)
//   - MARCH_ELEMS  : number of elements in the March C- sequence (6)
//   - march_elem() : the element table, indexed by element number
// -----------------------------------------------------------------------------
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int MARCH_ELEMS = 6;
  localparam int MARCH_IDX_W = 3;

  // An element is "read then write" when both has_rd and has_wr are set;
  // otherwise it is a single op per address.
  typedef struct packed {
    logic down;     // 1: address runs N-1..0, 0: address runs 0..N-1
    logic has_rd;   // element starts with a read at each address
    logic rd_ones;  // expected read data is all-ones (else all-zeros)
    logic has_wr;   // element writes each address (after the read, if any)
    logic wr_ones;  // write data is all-ones (else all-zeros)
  } march_elem_t;

  // March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)
  function automatic march_elem_t march_elem(input logic [MARCH_IDX_W-1:0] idx);
    march_elem_t e;
    case (idx)
      3'd0:    e = '{down: 1'b0, has_rd: 1'b0, rd_ones: 1'b0, has_wr: 1'b1, wr_ones: 1'b0};
      3'd1:    e = '{down: 1'b0, has_rd: 1'b1, rd_ones: 1'b0, has_wr: 1'b1, wr_ones: 1'b1};
      3'd2:    e = '{down: 1'b0, has_rd: 1'b1, rd_ones: 1'b1, has_wr: 1'b1, wr_ones: 1'b0};
      3'd3:    e = '{down: 1'b1, has_rd: 1'b1, rd_ones: 1'b0, has_wr: 1'b1, wr_ones: 1'b1};
      3'd4:    e = '{down: 1'b1, has_rd: 1'b1, rd_ones: 1'b1, has_wr: 1'b1, wr_ones: 1'b0};
      3'd5:    e = '{down: 1'b0, has_rd: 1'b1, rd_ones: 1'b0, has_wr: 1'b0, wr_ones: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sram_2p_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_2p_bist_ctrl_if
// Control/status handshake and SRAM port bundle of the BIST controller.
//   START      : request a test run
//   BUSY/DONE  : run in progress / run complete (held until next START)
//   FAIL       : sticky mismatch flag, FAIL_ADDR: first failing address
//   MEM_MEN/WEN/REN, MEM_ADDR, MEM_DIN : SRAM port controls and write data
//   MEM_DOUT   : SRAM read data (registered inside the SRAM)
// Modports: master = BIST controller, slave = system / SRAM side.
// -----------------------------------------------------------------------------
interface sram_2p_bist_ctrl_if #(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_ADDR_WIDTH = 9
);
  logic                    START;
  logic                    BUSY;
  logic                    DONE;
  logic                    FAIL;
  logic [P_ADDR_WIDTH-1:0] FAIL_ADDR;
  logic                    MEM_MEN;
  logic                    MEM_WEN;
  logic                    MEM_REN;
  logic [P_ADDR_WIDTH-1:0] MEM_ADDR;
  logic [P_DATA_WIDTH-1:0] MEM_DIN;
  logic [P_DATA_WIDTH-1:0] MEM_DOUT;

  modport master (
    input  START, MEM_DOUT,
    output BUSY, DONE, FAIL, FAIL_ADDR,
    output MEM_MEN, MEM_WEN, MEM_REN, MEM_ADDR, MEM_DIN
  );

  modport slave (
    output START, MEM_DOUT,
    input  BUSY, DONE, FAIL, FAIL_ADDR,
    input  MEM_MEN, MEM_WEN, MEM_REN, MEM_ADDR, MEM_DIN
  );
endinterface

// File: rtl/sram_bist_addr_gen.sv
// -----------------------------------------------------------------------------
// sram_bist_addr_gen
// Up/down address counter with terminal-count flag.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : load start address (all-ones if load_down_i, else zero)
//   step_i        : advance one address in the direction given by down_i
//   down_i        : current counting direction (selects terminal value)
//   addr_o        : current address
//   tc_o          : address is the last one for the current direction
// -----------------------------------------------------------------------------
module sram_bist_addr_gen #(
  parameter int P_ADDR_WIDTH = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    load_down_i,
  input  logic                    step_i,
  input  logic                    down_i,
  output logic [P_ADDR_WIDTH-1:0] addr_o,
  output logic                    tc_o
);
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_ADDR_WIDTH-1:0] addr_d;

  // Load wins over step so an element boundary never sees the wrapped value.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == '1);
endmodule

// File: rtl/sram_2p_bist_ctrl.sv
// -----------------------------------------------------------------------------
// sram_2p_bist_ctrl
// March C- BIST controller for one port of a 2-port SRAM. Issues one SRAM
// operation per cycle (10N total), compares read data one cycle after the
// SRAM registers it and records the first failing address.
//   CLK   : clock shared with the SRAM port
//   RST_N : synchronous active-low reset
//   bus   : handshake (START/BUSY/DONE/FAIL/FAIL_ADDR) and SRAM port
// Timing: START sampled at edge k; op i is driven after edge k+i; the last
// read is compared in DRAIN and DONE rises at edge k+10N+1.
// -----------------------------------------------------------------------------
module sram_2p_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_ADDR_WIDTH = 9
) (
  input logic                 CLK,
  input logic                 RST_N,
  sram_2p_bist_ctrl_if.master bus
);

  bist_state_e             state_q, state_d;
  logic [MARCH_IDX_W-1:0]  elem_q, elem_d;
  logic                    phase_q, phase_d;     // 0: read slot, 1: write slot
  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                    rd_pend_q, rd_pend_d; // read data arrives this cycle
  logic [P_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                    rd_ones_q, rd_ones_d;

  march_elem_t             cur;
  march_elem_t             nxt;
  logic                    op_rd, op_wr;
  logic                    last_of_addr;
  logic                    start_acc;
  logic                    mismatch;

  logic                    ag_load, ag_load_down, ag_step, ag_tc;
  logic [P_ADDR_WIDTH-1:0] ag_addr;

  assign cur = march_elem(elem_q);
  assign nxt = march_elem(elem_q + MARCH_IDX_W'(1));

  // Single-op elements finish an address in one slot; read-write elements
  // finish it in the write slot.
  assign last_of_addr = !(cur.has_rd && cur.has_wr) || phase_q;

  sram_bist_addr_gen #(
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .step_i      (ag_step),
    .down_i      (cur.down),
    .addr_o      (ag_addr),
    .tc_o        (ag_tc)
  );

  // Next-state and SRAM op decode
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    op_rd        = 1'b0;
    op_wr        = 1'b0;
    start_acc    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          start_acc    = 1'b1;
          state_d      = ST_RUN;
          elem_d       = '0;
          phase_d      = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = march_elem('0).down;
        end
      end
      ST_RUN: begin
        op_rd = cur.has_rd && !phase_q;
        op_wr = cur.has_wr && (phase_q || !cur.has_rd);
        if (!last_of_addr) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!ag_tc) begin
            ag_step = 1'b1;
          end else if (elem_q == MARCH_IDX_W'(MARCH_ELEMS - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d       = elem_q + MARCH_IDX_W'(1);
            ag_load      = 1'b1;
            ag_load_down = nxt.down;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-result check: the read issued last cycle is in MEM_DOUT now.
  assign mismatch = rd_pend_q && (bus.MEM_DOUT != {P_DATA_WIDTH{rd_ones_q}});

  always_comb begin
    rd_pend_d   = op_rd;
    rd_addr_d   = ag_addr;
    rd_ones_d   = cur.rd_ones;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    if (start_acc) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_ones_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      rd_ones_q   <= rd_ones_d;
    end
  end

  assign bus.BUSY      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.DONE      = (state_q == ST_DONE);
  assign bus.FAIL      = fail_q;
  assign bus.FAIL_ADDR = fail_addr_q;
  assign bus.MEM_MEN   = op_rd || op_wr;
  assign bus.MEM_WEN   = op_wr;
  assign bus.MEM_REN   = op_rd;
  assign bus.MEM_ADDR  = (state_q == ST_RUN) ? ag_addr : '0;
  assign bus.MEM_DIN   = op_wr ? {P_DATA_WIDTH{cur.wr_ones}} : '0;

endmodule

// File: doc/sram_2p_bist_ctrl.md
SRAM_2P_BIST_CTRL -- requirements
Module: sram_2p_bist_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 20: SRAM word width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 9: SRAM address width; N = 2**P_ADDR_WIDTH words.
REQ-003 SHALL have port CLK, input, 1: single clock, shared with the SRAM port it drives.
REQ-004 SHALL have port RST_N, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port START, input, 1: request a test run; sampled only in IDLE or DONE.
REQ-006 SHALL have port BUSY, output, 1: high while a run is in progress.
REQ-007 SHALL have port DONE, output, 1: high once a run completes; held until the next START or reset.
REQ-008 SHALL have port FAIL, output, 1: sticky mismatch flag for the current run.
REQ-009 SHALL have port FAIL_ADDR, output, P_ADDR_WIDTH: address of the first mismatch.
REQ-010 SHALL have ports MEM_MEN, MEM_WEN and MEM_REN, each output, 1: SRAM port controls.
REQ-011 SHALL have port MEM_ADDR, output, P_ADDR_WIDTH: SRAM address.
REQ-012 SHALL have port MEM_DIN, output, P_DATA_WIDTH: SRAM write data.
REQ-013 SHALL have port MEM_DOUT, input, P_DATA_WIDTH: SRAM read data, registered by the SRAM on the read edge.

Function
REQ-014 SHALL run March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0), where 0 = all-zeros and 1 = all-ones.
REQ-015 SHALL issue exactly one SRAM operation per cycle, for 10N operations in total.
REQ-016 SHALL, within a read-write element, read an address and then write the same address on the next cycle before advancing.
REQ-017 SHALL drive a write as MEN=1, WEN=1, REN=0 and a read as MEN=1, WEN=0, REN=1.
REQ-018 SHALL drive MEN, WEN and REN to 0 in IDLE, DRAIN and DONE.
REQ-019 SHALL use FSM states IDLE -> RUN -> DRAIN -> DONE, with DONE -> RUN on START.
REQ-020 SHALL enter RUN when START is sampled at edge k in IDLE or DONE; that edge also clears FAIL, FAIL_ADDR and DONE.
REQ-021 SHALL present operation i (i = 0..10N-1) during the cycle after edge k+i, so the SRAM captures it at edge k+i+1.
REQ-022 SHALL compare MEM_DOUT with the expected value, pipelined one cycle, at the edge after each read capture.
REQ-023 SHALL enter DRAIN after the last operation and DONE at edge k+10N+1; DONE and BUSY are mutually exclusive.
REQ-024 SHALL, on the first mismatch, set FAIL and load FAIL_ADDR with the read's address; later mismatches leave FAIL_ADDR unchanged.
REQ-025 SHALL wrap address counters without overflow: up runs 0..N-1, down runs N-1..0.
REQ-026 SHALL ignore START in RUN and DRAIN.
REQ-027 SHALL hold a mismatch seen on the final read (compared in DRAIN) in FAIL before DONE rises.

Reset
REQ-028 SHALL, when RST_N is low at an edge, force state IDLE and BUSY=DONE=FAIL=0, FAIL_ADDR=0, MEM_*=0, counters=0, from any state including mid-run.
REQ-029 SHALL not issue SRAM operations or compare results in the cycle after reset is released.

Structure
REQ-030 SHALL place the FSM state enum, the March element table (direction, op sequence, data polarity) and its element count of 6 in the shared package sram_bist_pkg.
REQ-031 SHALL contain one sub-module, sram_bist_addr_gen: an up/down address counter with a terminal-count flag.

Verification
REQ-032 SHALL cover: P_ADDR_WIDTH=4 with a fault-free 2P SRAM model; START pulse -> BUSY for 161 cycles, DONE at cycle 161, FAIL=0.
REQ-033 SHALL cover: model word 5 bit 0 stuck at 1 -> FAIL=1, FAIL_ADDR=5, DONE still at cycle 161.
REQ-034 SHALL cover: address-bit-2 coupling fault (writes to 3 also hit 7) -> FAIL=1, FAIL_ADDR=7, the first failing read in up(r0,w1).
REQ-035 SHALL cover: RST_N low for 1 cycle at cycle 40 of a run -> next edge IDLE with all outputs 0; a new START yields a clean 161-cycle run.
REQ-036 SHALL cover: START held high throughout a run -> no restart before DONE; DONE lasts 1 cycle before the next run begins.
REQ-037 SHALL cover: fault only in the last up(r0) read of word 15 -> FAIL=1 and FAIL_ADDR=15, visible at the edge DONE rises.
